gpio_in: RTL

//  Wishbone-slave GPIO input port; input counterpart of the GPIO output peripheral on the SERV data bus.

---
 rtl/gpio_in.sv | 95 +++++++++
 1 files changed

// File: rtl/gpio_in.sv
// Wishbone-slave GPIO input port: synchronises external pins, latches enabled
// rising/falling edges into sticky write-1-to-clear status bits and raises a level irq.
module gpio_in #(
    parameter logic [7:0] ADDR  = 8'h00,
    parameter int         WIDTH = 8
) (
    input  logic             wb_clk,
    input  logic             wb_rst_n,
    input  logic [31:0]      wb_dbus_adr,
    input  logic [31:0]      wb_dbus_dat,
    input  logic [3:0]       wb_dbus_sel,
    input  logic             wb_dbus_we,
    input  logic             wb_dbus_cyc,
    output logic [31:0]      rdt,
    output logic             ack,
    output logic             irq,
    input  logic [WIDTH-1:0] pins
);

    logic [WIDTH-1:0] s1_q, s2_q, prev_q;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] edge_set, status_clr;
    logic [31:0]      rdt_q, rd_val;
    logic             ack_q, irq_q;
    logic             sel, access, wr, rd;
    logic [1:0]       idx;
    logic             unused_ok;

    // Byte enables and the undecoded address/data bits have no effect.
    assign unused_ok = &{1'b0, wb_dbus_sel, wb_dbus_adr, wb_dbus_dat};

    assign sel    = wb_dbus_cyc && (wb_dbus_adr[31:24] == ADDR);
    assign access = sel && !ack_q;
    assign wr     = access && wb_dbus_we;
    assign rd     = access && !wb_dbus_we;
    assign idx    = wb_dbus_adr[3:2];

    always_comb begin
        rd_val = '0;
        case (idx)
            2'd0:    rd_val[WIDTH-1:0] = s2_q;
            2'd1:    rd_val[WIDTH-1:0] = rise_en_q;
            2'd2:    rd_val[WIDTH-1:0] = fall_en_q;
            default: rd_val[WIDTH-1:0] = status_q;
        endcase
    end

    // A set and a clear on the same bit in the same cycle resolve to set.
    always_comb begin
        rise_en_d  = rise_en_q;
        fall_en_d  = fall_en_q;
        status_clr = '0;
        if (wr) begin
            case (idx)
                2'd1:    rise_en_d  = wb_dbus_dat[WIDTH-1:0];
                2'd2:    fall_en_d  = wb_dbus_dat[WIDTH-1:0];
                2'd3:    status_clr = wb_dbus_dat[WIDTH-1:0];
                default: ;
            endcase
        end
        edge_set = (s2_q & ~prev_q & rise_en_q) | (~s2_q & prev_q & fall_en_q);
        status_d = (status_q & ~status_clr) | edge_set;
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            prev_q    <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            ack_q     <= 1'b0;
            rdt_q     <= '0;
            irq_q     <= 1'b0;
        end else begin
            s1_q      <= pins;
            s2_q      <= s1_q;
            prev_q    <= s2_q;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            ack_q     <= access;
            rdt_q     <= rd ? rd_val : '0;
            irq_q     <= |status_d;
        end
    end

    assign ack = ack_q;
    assign rdt = rdt_q;
    assign irq = irq_q;

endmodule
